// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: fetch FSM states, reset PC,
// instruction field positions and PC increment.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int JIDX_W    = 26;

    localparam int PC_INC = 4;

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Pure combinational next-PC selection: sequential, branch and jump targets,
// with jump taking priority over a taken branch.
module pc_next_sel
    import mips_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0]     pc,
    input  logic [JIDX_W-1:0] jidx,
    input  logic [31:0]       signimm,
    input  logic              jump,
    input  logic              pcsrc,
    output logic [AW-1:0]     pcplus4,
    output logic [AW-1:0]     pcnext
);

    logic [AW-1:0] pcbranch;
    logic [AW-1:0] pcjump;

    assign pcplus4  = pc + AW'(PC_INC);
    // Word offset scaled to bytes; wraps modulo 2^AW like every other add.
    assign pcbranch = pcplus4 + AW'({signimm, 2'b00});
    assign pcjump   = {pcplus4[AW-1:JIDX_W+2], jidx, 2'b00};

    always_comb begin
        pcnext = pcplus4;
        if (jump) begin
            pcnext = pcjump;
        end else if (pcsrc) begin
            pcnext = pcbranch;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests instructions over a req/ack handshake,
// holds the fetched word until retire, then advances the PC.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic [31:0]   instr,
    output logic          instr_valid,
    input  logic          retire,
    input  logic          pcsrc,
    input  logic          jump,
    input  logic [31:0]   signimm,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pcplus4
);

    fetch_state_t  state_reg, state_next;
    logic [AW-1:0] pc_reg;
    logic [31:0]   instr_reg;
    logic [AW-1:0] pcnext;
    logic          load_instr;
    logic          load_pc;

    pc_next_sel #(.AW(AW)) u_pc_next_sel (
        .pc      (pc_reg),
        .jidx    (instr_reg[JIDX_W-1:0]),
        .signimm (signimm),
        .jump    (jump),
        .pcsrc   (pcsrc),
        .pcplus4 (pcplus4),
        .pcnext  (pcnext)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            instr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (load_pc) begin
                pc_reg <= pcnext;
            end
            if (load_instr) begin
                instr_reg <= imem_rdata;
            end
        end
    end

    // ack and retire only matter in the state that is waiting for them.
    always_comb begin
        state_next  = state_reg;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        load_instr  = 1'b0;
        load_pc     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    load_instr = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (retire) begin
                    load_pc    = 1'b1;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem_addr = pc_reg;
    assign pc        = pc_reg;
    assign instr     = instr_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed table, reset corner cases, then random
// transactions checked against an arithmetic next-PC model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        retire;
    logic        pcsrc;
    logic        jump;
    logic [31:0] signimm;
    logic [31:0] pc;
    logic [31:0] pcplus4;

    int vec_count  = 0;
    int miscompares = 0;
    int txn_count  = 0;
    logic [31:0] model_pc;

    typedef struct {
        logic [31:0] rdata;
        int          delay;
        logic        jump;
        logic        pcsrc;
        logic [31:0] signimm;
        logic [31:0] exp_pc;
    } rec_t;

    rec_t tbl [10];

    fetch_unit #(.AW(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .retire      (retire),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .signimm     (signimm),
        .pc          (pc),
        .pcplus4     (pcplus4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Next PC from the architectural rules, written as plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic j, input logic b, input logic [31:0] simm);
        logic [31:0] seq;
        seq = cur + 32'd4;
        if (j)      return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
        else if (b) return seq + simm * 32'd4;
        else        return seq;
    endfunction

    task automatic run_txn(input logic [31:0] rdata, input int delay, input logic j,
                           input logic b, input logic [31:0] simm, input logic [31:0] exp_next);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== 1'b1) begin
            chk("req_timeout", {31'd0, imem_req}, 32'd1);
            return;
        end
        chk("addr", imem_addr, model_pc);
        chk("pcplus4_pre", pcplus4, model_pc + 32'd4);
        // Wait states, with a spurious retire that must be ignored in FETCH.
        for (int d = 0; d < delay; d++) begin
            retire = 1'b1; jump = 1'b1; pcsrc = 1'b1; signimm = $urandom;
            @(negedge clk);
            chk("req_hold", {31'd0, imem_req}, 32'd1);
            chk("addr_hold", imem_addr, model_pc);
            chk("valid_wait", {31'd0, instr_valid}, 32'd0);
            chk("pc_wait", pc, model_pc);
        end
        retire = 1'b0; jump = 1'b0; pcsrc = 1'b0;
        imem_ack = 1'b1; imem_rdata = rdata;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = $urandom;
        chk("valid_hold", {31'd0, instr_valid}, 32'd1);
        chk("instr", instr, rdata);
        chk("req_hold_low", {31'd0, imem_req}, 32'd0);
        // Spurious ack in HOLD must not overwrite the instruction.
        imem_ack = 1'b1; imem_rdata = ~rdata;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("instr_keep", instr, rdata);
        chk("valid_keep", {31'd0, instr_valid}, 32'd1);
        retire = 1'b1; jump = j; pcsrc = b; signimm = simm;
        @(negedge clk);
        retire = 1'b0; jump = 1'b0; pcsrc = 1'b0;
        chk("pc_next", pc, exp_next);
        chk("pcplus4_post", pcplus4, exp_next + 32'd4);
        chk("valid_retired", {31'd0, instr_valid}, 32'd0);
        $display("txn %0d: pc=%h instr=%h j=%0d b=%0d simm=%h wait=%0d -> pc=%h (exp %h)",
                 txn_count, model_pc, rdata, j, b, simm, delay, pc, exp_next);
        txn_count++;
        model_pc = exp_next;
    endtask

    initial begin
        tbl[0] = '{32'h2008_0005, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004};
        tbl[1] = '{32'h1000_0002, 1, 1'b0, 1'b1, 32'h0000_0002, 32'h0000_0010};
        tbl[2] = '{32'h1000_FFFE, 0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_000C};
        tbl[3] = '{32'h0000_0020, 2, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0010};
        tbl[4] = '{32'h1000_0003, 5, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_0020};
        tbl[5] = '{32'h1000_0007, 0, 1'b0, 1'b1, 32'h2000_0007, 32'h8000_0040};
        tbl[6] = '{32'h0800_0010, 1, 1'b1, 1'b1, 32'h0000_0005, 32'h8000_0040};
        tbl[7] = '{32'h1000_0000, 0, 1'b0, 1'b1, 32'h1FFF_FFEE, 32'hFFFF_FFFC};
        tbl[8] = '{32'h0000_0000, 3, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[9] = '{32'h0800_0010, 0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0040};

        reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        retire = 1'b0; pcsrc = 1'b0; jump = 1'b0; signimm = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        model_pc = 32'h0;
        // First cycle after release is the dead IDLE cycle.
        chk("idle_req", {31'd0, imem_req}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].rdata, tbl[i].delay, tbl[i].jump, tbl[i].pcsrc,
                    tbl[i].signimm, tbl[i].exp_pc);
        end

        // Reset mid-FETCH, then a late ack arriving in IDLE.
        repeat (2) @(negedge clk);
        chk("fetch_before_rst", {31'd0, imem_req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rstf_req", {31'd0, imem_req}, 32'd0);
        chk("rstf_pc", pc, 32'h0);
        chk("rstf_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("late_ack_instr", instr, 32'h0);
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        chk("late_ack_req", {31'd0, imem_req}, 32'd1);
        $display("txn %0d: reset mid-FETCH, late ack ignored, instr=%h", txn_count, instr);
        txn_count++;

        // Reset in HOLD discards the pending instruction at once.
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rsth_valid", {31'd0, instr_valid}, 32'd0);
        chk("rsth_instr", instr, 32'h0);
        chk("rsth_pc", pc, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        $display("txn %0d: reset in HOLD, valid=%0d instr=%h", txn_count, instr_valid, instr);
        txn_count++;
        model_pc = 32'h0;

        for (int i = 0; i < 40; i++) begin
            logic [31:0] w, s, e;
            logic        j, b;
            int          dly;
            w   = $urandom;
            j   = ($urandom_range(0, 3) == 0);
            b   = ($urandom_range(0, 2) == 0);
            s   = {{16{w[15]}}, w[15:0]} ^ {16'h0, 16'($urandom)};
            s   = {{16{s[15]}}, s[15:0]};
            dly = $urandom_range(0, 3);
            e   = ref_next(model_pc, w, j, b, s);
            run_txn(w, dly, j, b, s, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
